// File: rtl/m2v_side_pkg.sv
// Shared packing layout for one side-information entry (LSB first:
// x, y, intra, block, coded, enable) and the entry-width helper.
package m2v_side_pkg;

    localparam int unsigned W_INTRA  = 1;
    localparam int unsigned W_BLOCK  = 3;
    localparam int unsigned W_CODED  = 1;
    localparam int unsigned W_ENABLE = 1;
    localparam int unsigned W_FLAGS  = W_INTRA + W_BLOCK + W_CODED + W_ENABLE;

    function automatic int unsigned entry_width(input int unsigned mbx_w,
                                                input int unsigned mby_w);
        return mbx_w + mby_w + W_FLAGS;
    endfunction

    function automatic int unsigned off_x();
        return 0;
    endfunction

    function automatic int unsigned off_y(input int unsigned mbx_w);
        return mbx_w;
    endfunction

    function automatic int unsigned off_intra(input int unsigned mbx_w,
                                              input int unsigned mby_w);
        return mbx_w + mby_w;
    endfunction

    function automatic int unsigned off_block(input int unsigned mbx_w,
                                              input int unsigned mby_w);
        return off_intra(mbx_w, mby_w) + W_INTRA;
    endfunction

    function automatic int unsigned off_coded(input int unsigned mbx_w,
                                              input int unsigned mby_w);
        return off_block(mbx_w, mby_w) + W_BLOCK;
    endfunction

    function automatic int unsigned off_enable(input int unsigned mbx_w,
                                               input int unsigned mby_w);
        return off_coded(mbx_w, mby_w) + W_CODED;
    endfunction

endpackage

// File: rtl/m2vside_ram.sv
// Flop-based storage array: one synchronous write port, one asynchronous
// read port, cleared by the asynchronous reset.
module m2vside_ram #(
    parameter int unsigned WIDTH      = 20,
    parameter int unsigned DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_we,
    input  logic [DEPTH_LOG2-1:0] i_waddr,
    input  logic [WIDTH-1:0]      i_wdata,
    input  logic [DEPTH_LOG2-1:0] i_raddr,
    output logic [WIDTH-1:0]      o_rdata
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/m2vside_fifo.sv
// Show-ahead side-information FIFO between MPEG2 decoder stages.
// Optional sticky overflow/underflow flag: define M2VSIDE_FIFO_ERR_EN.
module m2vside_fifo
    import m2v_side_pkg::*;
#(
    parameter int unsigned MBX_WIDTH  = 7,
    parameter int unsigned MBY_WIDTH  = 7,
    parameter int unsigned DEPTH_LOG2 = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [MBX_WIDTH-1:0] in_mb_x,
    input  logic [MBY_WIDTH-1:0] in_mb_y,
    input  logic                 in_mb_intra,
    input  logic [2:0]           in_block,
    input  logic                 in_coded,
    input  logic                 in_enable,
    input  logic                 push,
    input  logic                 pop,
    output logic [MBX_WIDTH-1:0] out_mb_x,
    output logic [MBY_WIDTH-1:0] out_mb_y,
    output logic                 out_mb_intra,
    output logic [2:0]           out_block,
    output logic                 out_coded,
    output logic                 out_enable,
    output logic                 out_valid,
    output logic                 full,
`ifdef M2VSIDE_FIFO_ERR_EN
    output logic                 err,
`endif
    output logic [DEPTH_LOG2:0]  level
);

    localparam int unsigned EW    = entry_width(MBX_WIDTH, MBY_WIDTH);
    localparam int unsigned O_X   = off_x();
    localparam int unsigned O_Y   = off_y(MBX_WIDTH);
    localparam int unsigned O_INT = off_intra(MBX_WIDTH, MBY_WIDTH);
    localparam int unsigned O_BLK = off_block(MBX_WIDTH, MBY_WIDTH);
    localparam int unsigned O_COD = off_coded(MBX_WIDTH, MBY_WIDTH);
    localparam int unsigned O_EN  = off_enable(MBX_WIDTH, MBY_WIDTH);

    logic [DEPTH_LOG2:0] r_wr_ptr;
    logic [DEPTH_LOG2:0] r_rd_ptr;
    logic                w_empty;
    logic                w_full;
    logic                w_push_ok;
    logic                w_pop_ok;
    logic [EW-1:0]       w_wdata;
    logic [EW-1:0]       w_rdata;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]) &&
                     (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]);

    // A pop on a full queue frees the head slot in the same edge, so the push lands there.
    assign w_pop_ok  = pop & ~w_empty;
    assign w_push_ok = push & (~w_full | pop);

    always_comb begin
        w_wdata                      = '0;
        w_wdata[O_X +: MBX_WIDTH]    = in_mb_x;
        w_wdata[O_Y +: MBY_WIDTH]    = in_mb_y;
        w_wdata[O_INT +: W_INTRA]    = in_mb_intra;
        w_wdata[O_BLK +: W_BLOCK]    = in_block;
        w_wdata[O_COD +: W_CODED]    = in_coded;
        w_wdata[O_EN +: W_ENABLE]    = in_enable;
    end

    m2vside_ram #(
        .WIDTH      (EW),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk     (clk),
        .reset_n (reset_n),
        .i_we    (w_push_ok),
        .i_waddr (r_wr_ptr[DEPTH_LOG2-1:0]),
        .i_wdata (w_wdata),
        .i_raddr (r_rd_ptr[DEPTH_LOG2-1:0]),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

`ifdef M2VSIDE_FIFO_ERR_EN
    logic r_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err <= 1'b0;
        end else if ((push & w_full & ~pop) | (pop & w_empty)) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`endif

    assign out_mb_x     = w_rdata[O_X +: MBX_WIDTH];
    assign out_mb_y     = w_rdata[O_Y +: MBY_WIDTH];
    assign out_mb_intra = w_rdata[O_INT];
    assign out_block    = w_rdata[O_BLK +: W_BLOCK];
    assign out_coded    = w_rdata[O_COD];
    assign out_enable   = w_rdata[O_EN] & ~w_empty;
    assign out_valid    = ~w_empty;
    assign full         = w_full;
    assign level        = r_wr_ptr - r_rd_ptr;

endmodule

// File: tb/tb_m2vside_fifo.sv
// Scoreboard bench for m2vside_fifo: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_m2vside_fifo;

    localparam int unsigned MBXW  = 7;
    localparam int unsigned MBYW  = 7;
    localparam int unsigned DL2   = 2;
    localparam int unsigned DEPTH = 4;

    logic            clk;
    logic            reset_n;
    logic [MBXW-1:0] in_mb_x;
    logic [MBYW-1:0] in_mb_y;
    logic            in_mb_intra;
    logic [2:0]      in_block;
    logic            in_coded;
    logic            in_enable;
    logic            push;
    logic            pop;
    logic [MBXW-1:0] out_mb_x;
    logic [MBYW-1:0] out_mb_y;
    logic            out_mb_intra;
    logic [2:0]      out_block;
    logic            out_coded;
    logic            out_enable;
    logic            out_valid;
    logic            full;
    logic            err;
    logic [DL2:0]    level;

    m2vside_fifo #(
        .MBX_WIDTH  (MBXW),
        .MBY_WIDTH  (MBYW),
        .DEPTH_LOG2 (DL2)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_mb_x      (in_mb_x),
        .in_mb_y      (in_mb_y),
        .in_mb_intra  (in_mb_intra),
        .in_block     (in_block),
        .in_coded     (in_coded),
        .in_enable    (in_enable),
        .push         (push),
        .pop          (pop),
        .out_mb_x     (out_mb_x),
        .out_mb_y     (out_mb_y),
        .out_mb_intra (out_mb_intra),
        .out_block    (out_block),
        .out_coded    (out_coded),
        .out_enable   (out_enable),
        .out_valid    (out_valid),
        .full         (full),
`ifdef M2VSIDE_FIFO_ERR_EN
        .err          (err),
`endif
        .level        (level)
    );

`ifndef M2VSIDE_FIFO_ERR_EN
    assign err = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned x;
        int unsigned y;
        int unsigned intra;
        int unsigned blk;
        int unsigned coded;
        int unsigned en;
    } ent_t;

    ent_t mdl[$];
    ent_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   err_exp = 1'b0;
    bit   prev_push = 1'b0;
    bit   prev_pop = 1'b0;
    ent_t prev_d;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ent_t mk(input int unsigned x, input int unsigned y,
                                input int unsigned intra, input int unsigned blk,
                                input int unsigned coded, input int unsigned en);
        ent_t e;
        e.x = x; e.y = y; e.intra = intra; e.blk = blk; e.coded = coded; e.en = en;
        return e;
    endfunction

    function automatic ent_t rand_ent();
        return mk($urandom_range(0, 127), $urandom_range(0, 127), $urandom_range(0, 1),
                  $urandom_range(0, 5), $urandom_range(0, 1), $urandom_range(0, 1));
    endfunction

    // Apply the strobes that the last clock edge consumed to the reference queue.
    function automatic void commit();
        int unsigned n;
        bit          pop_ok;
        bit          push_ok;
        n       = mdl.size();
        pop_ok  = prev_pop && (n > 0);
        push_ok = prev_push && ((n < DEPTH) || prev_pop);
        if (prev_pop && n == 0) err_exp = 1'b1;
        if (prev_push && !prev_pop && n == DEPTH) err_exp = 1'b1;
        if (pop_ok) void'(mdl.pop_front());
        if (push_ok) mdl.push_back(prev_d);
    endfunction

    task automatic step(input bit p, input bit q, input ent_t d);
        @(posedge clk);
        #1;
        commit();
        push        = p;
        pop         = q;
        in_mb_x     = MBXW'(d.x);
        in_mb_y     = MBYW'(d.y);
        in_mb_intra = d.intra[0];
        in_block    = 3'(d.blk);
        in_coded    = d.coded[0];
        in_enable   = d.en[0];
        if (q && mdl.size() > 0) sb_q.push_back(mdl[0]);
        prev_push = p;
        prev_pop  = q;
        prev_d    = d;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_level"}, level, 0);
        chk({tag, "_full"}, full, 0);
        chk({tag, "_enable"}, out_enable, 0);
        chk({tag, "_fields"}, {out_mb_x, out_mb_y, out_mb_intra, out_block, out_coded}, 0);
`ifdef M2VSIDE_FIFO_ERR_EN
        chk({tag, "_err"}, err, 0);
`endif
    endtask

    task automatic mid_reset();
        push = 1'b0;
        pop  = 1'b0;
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("midreset");
        mdl.delete();
        sb_q.delete();
        prev_push = 1'b0;
        prev_pop  = 1'b0;
        err_exp   = 1'b0;
        #3 reset_n = 1'b1;
    endtask

    // Monitor: status against the model every cycle, head fields on each effective pop.
    always @(negedge clk) begin
        int unsigned n;
        ent_t        e;
        if (reset_n) begin
            n = mdl.size();
            chk("level", level, n);
            chk("full", full, (n == DEPTH) ? 1 : 0);
            chk("out_valid", out_valid, (n > 0) ? 1 : 0);
            chk("out_enable", out_enable, (n > 0) ? mdl[0].en : 0);
`ifdef M2VSIDE_FIFO_ERR_EN
            chk("err", err, err_exp);
`endif
            if (pop && out_valid) begin
                if (sb_q.size() == 0) begin
                    chk("sb_expected_entry", 0, 1);
                end else begin
                    e = sb_q.pop_front();
                    chk("head_x", out_mb_x, e.x);
                    chk("head_y", out_mb_y, e.y);
                    chk("head_intra", out_mb_intra, e.intra);
                    chk("head_block", out_block, e.blk);
                    chk("head_coded", out_coded, e.coded);
                end
            end
        end
    end

    initial begin
        reset_n = 1'b0; push = 1'b0; pop = 1'b0;
        in_mb_x = '0; in_mb_y = '0; in_mb_intra = 1'b0;
        in_block = '0; in_coded = 1'b0; in_enable = 1'b0;
        prev_d = mk(0, 0, 0, 0, 0, 0);
        #12 check_reset_outputs("reset");
        #5 reset_n = 1'b1;
        repeat (2) idle();
        check_reset_outputs("idle");

        // Single push becomes visible the next cycle.
        step(1'b1, 1'b0, mk(5, 3, 0, 2, 1, 1));
        idle();
        chk("single_valid", out_valid, 1);
        chk("single_x", out_mb_x, 5);
        chk("single_block", out_block, 2);
        chk("single_level", level, 1);
        step(1'b0, 1'b1, mk(0, 0, 0, 0, 0, 0));
        idle();

        // Fill, overflow, drain in order.
        for (int unsigned i = 1; i <= 5; i++) step(1'b1, 1'b0, mk(i, 10 + i, i % 2, i, 1, 1));
        idle();
        chk("fill_full", full, 1);
        chk("fill_level", level, 4);
`ifdef M2VSIDE_FIFO_ERR_EN
        chk("overflow_err", err, 1);
`endif
        repeat (4) step(1'b0, 1'b1, mk(0, 0, 0, 0, 0, 0));
        idle();
        chk("drain_level", level, 0);

        // Push+pop at level 2 and at full.
        repeat (2) step(1'b1, 1'b0, rand_ent());
        step(1'b1, 1'b1, rand_ent());
        idle();
        chk("pp2_level", level, 2);
        repeat (2) step(1'b1, 1'b0, rand_ent());
        step(1'b1, 1'b1, mk(99, 77, 1, 5, 0, 1));
        idle();
        chk("ppfull_full", full, 1);
        chk("ppfull_level", level, 4);
        repeat (4) step(1'b0, 1'b1, mk(0, 0, 0, 0, 0, 0));

        // Pop on empty, then push+pop on empty.
        step(1'b0, 1'b1, mk(0, 0, 0, 0, 0, 0));
        idle();
        chk("popempty_level", level, 0);
        step(1'b1, 1'b1, mk(33, 44, 0, 3, 1, 1));
        idle();
        chk("ppempty_level", level, 1);
        step(1'b0, 1'b1, mk(0, 0, 0, 0, 0, 0));

        // Pointer wrap with a sustained push/pop stream.
        step(1'b1, 1'b0, rand_ent());
        repeat (20) step(1'b1, 1'b1, rand_ent());
        step(1'b0, 1'b1, mk(0, 0, 0, 0, 0, 0));
        idle();

        // Random traffic.
        for (int unsigned i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45, rand_ent());
        end
        repeat (DEPTH + 1) step(1'b0, 1'b1, mk(0, 0, 0, 0, 0, 0));
        idle();

        // Reset at level 3 clears everything at once.
        repeat (3) step(1'b1, 1'b0, rand_ent());
        idle();
        chk("prereset_level", level, 3);
        mid_reset();
        repeat (3) step(1'b1, 1'b0, rand_ent());
        repeat (3) step(1'b0, 1'b1, mk(0, 0, 0, 0, 0, 0));
        idle();
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/m2vside_fifo.md
# m2vside_fifo

Parametrised side-information queue for the MPEG2 video decoder pipeline. It carries per-block side information (macroblock position, intra flag, block index, coded flag, enable) from the stage that produces it to the stage that consumes it, so that several blocks can be in flight between stages. It replaces a single-entry latch with a configurable-depth, show-ahead FIFO that has explicit full/empty/level status. Push and pop are single-cycle strobes, typically the upstream and downstream `block_start` pulses.

## Interface
- `MBX_WIDTH`, default 7: width of the macroblock X coordinate.
- `MBY_WIDTH`, default 7: width of the macroblock Y coordinate.
- `DEPTH_LOG2`, default 2: log2 of the entry count. Depth is 2^DEPTH_LOG2. Legal range is 1..4.

- `clk`  in  1: clock. All state changes on the rising edge.
- `reset_n`  in  1: reset, asynchronous, active-low.
- `in_mb_x`  in  MBX_WIDTH: X coordinate of the entry being pushed.
- `in_mb_y`  in  MBY_WIDTH: Y coordinate of the entry being pushed.
- `in_mb_intra`  in  1: intra flag of the entry being pushed.
- `in_block`  in  3: block index 0..5.
- `in_coded`  in  1: coded-block flag.
- `in_enable`  in  1: entry-enable flag.
- `push`  in  1: write strobe. Captures all `in_*` fields in the same cycle.
- `pop`  in  1: read strobe. Advances the head of the queue.
- `out_mb_x`, `out_mb_y`, `out_mb_intra`, `out_block`, `out_coded`  out: fields of the head entry. Same widths as the matching `in_*` ports.
- `out_enable`  out  1: head entry's enable flag, ANDed with `out_valid`.
- `out_valid`  out  1: the queue is not empty.
- `full`  out  1: level equals 2^DEPTH_LOG2.
- `level`  out  DEPTH_LOG2+1: number of stored entries.
- `err`  out  1: sticky overflow/underflow flag. Present only when `M2VSIDE_FIFO_ERR_EN` is defined.

## Operation
- Storage is 2^DEPTH_LOG2 flop entries. Each entry is MBX_WIDTH+MBY_WIDTH+6 bits.
- Write and read pointers are DEPTH_LOG2+1 bits wide. The MSB is a wrap bit.
  - Empty: pointers are equal.
  - Full: index bits are equal and wrap bits differ.
  - `level` is `wr_ptr - rd_ptr`, taken modulo 2^(DEPTH_LOG2+1).
- Show-ahead behaviour: `out_*` is driven combinationally from `mem[rd_ptr]` through a register mux. There is no separate output register.
- Accepted push: entry written to `mem[wr_ptr]`, then `wr_ptr` increments.
- Accepted pop: `rd_ptr` increments. The entry contents are not cleared.
- Push while full and pop low: push is dropped and all state is unchanged.
- Push while full and pop high: both are accepted. Level stays at full.
- Pop while empty: ignored. A simultaneous push while empty is accepted, so level goes to 1.
- Push and pop both accepted: level is unchanged and the pointers advance together.
- While empty, `out_enable` reads 0. The other `out_*` fields show stale storage and are don't-care.
- Pointers wrap naturally at 2^(DEPTH_LOG2+1).
- Reset values (asynchronous):
  - Pointers 0 and all storage 0.
  - `out_valid`=0, `full`=0, `level`=0, `out_enable`=0, all `out_*` fields 0.
  - `err`=0 when present.
- A reset mid-operation discards all entries immediately.

## Timing
- Push to visible: a push in cycle N makes the entry visible on `out_*` and raises `out_valid` in cycle N+1 when the queue was empty.
- Pop to next entry: a pop in cycle N presents the next entry in cycle N+1.
- `full`, `level` and `out_valid` all update in the cycle after the strobe.
- No combinational path runs from `push` or `pop` to any output.
- Sustained throughput: one push and one pop per cycle.

## Configuration
- `M2VSIDE_FIFO_ERR_EN` defined:
  - `err` port exists.
  - `err` is set on a dropped push (full with no pop) or on a pop while empty.
  - `err` is cleared only by reset.
- Not defined:
  - `err` port and its flop are absent.
  - Overflow and underflow are silently ignored as described above.

## Structure
- The shared package `m2v_side_pkg` holds:
  - field offset and width constants for the packed entry (x, y, intra, block, coded, enable order, LSB first);
  - the entry-width expression.
- One sub-module, `m2vside_ram`: the flop array with one write port and one asynchronous read port, parametrised by width and depth.
- Pointer, status and error logic stay in `m2vside_fifo`.

## Test plan
- **Reset then idle.** Assert reset, release it, no strobes → `out_valid`=0, `level`=0, `full`=0, `out_enable`=0.
- **Single push.** DEPTH_LOG2=2. Push x=5, y=3, block=2, coded=1, enable=1 → next cycle `out_valid`=1, `out_mb_x`=5, `out_block`=2, `level`=1.
- **Fill, overflow, drain.** Push 5 distinct entries with no pop → `full`=1 after the 4th push, `level`=4, the 5th push is dropped (`err`=1 with the macro defined). Then pop 4 times → entries appear in order 1..4, `level`=0.
- **Simultaneous push and pop.** Push and pop together at level 2 → `level` stays 2 and the head advances. Push and pop together at level 4 → `full` stays 1 and the new entry is stored.
- **Pop while empty.** Pop on an empty queue → no state change, `err`=1 with the macro defined. Push and pop together on an empty queue → `level`=1.
- **Wrap and mid-stream reset.** Run 20 push/pop pairs so the pointers wrap → FIFO order is preserved. Assert reset at level 3 → all outputs return to their reset values in the same cycle.
